jt10_adpcm_accn: RTL and testbench
==================================

# jt10_adpcm_accn

Parametrised channel mixer and sample-rate interpolator for the ADPCM path. Sums CH time-multiplexed channel samples per frame, with an optional per-channel mute. Raises the frame rate by an integer factor INTERP through linear interpolation between successive frame sums. Saturates or wraps the result to a W-bit output. Sits between the ADPCM decoders and the FM/PSG output mixer.

## Interface
- CH, 6, channels per frame (2..8)
- W, 16, sample width in/out
- INTERP, 3, output samples per frame; must divide CH exactly (1..CH)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cen  in  1  channel-slot strobe; one channel slot per cen
- cur_ch  in  3  channel index of current slot, counts 0..CH-1
- chan_mask  in  CH  bit n = 1 enables channel n
- pcm_in  in  W  signed sample of channel cur_ch
- pcm_out  out  W  signed interpolated mix
- pcm_valid  out  1  one-clk pulse when pcm_out updates

## Operation
- Local widths:
  - AW = W + clog2(CH): accumulator, targets.
  - DW = AW + 1: diff, step, y.
  - RECIP = round(65536/INTERP).
  - SLOT = CH/INTERP.
- Accumulate, on cen:
  - Term = chan_mask[cur_ch] ? sign-extended pcm_in : 0.
  - cur_ch == 0: acc <= term.
  - 0 < cur_ch < CH: acc <= acc + term.
  - cur_ch ≥ CH: slot ignored, no state changes.
- Frame boundary (cen with cur_ch == 0):
  - done = acc (completed previous frame).
  - step <= ((done − tgt) × RECIP) >>> 16, arithmetic, floor.
  - y <= tgt.
  - tgt <= done.
- Interpolate:
  - On cen with cur_ch == k·SLOT, k = 1..INTERP−1: y <= y + step.
  - No other slot changes y.
- Output:
  - On every boundary or interpolation cen, pcm_out <= fmt(new y) and pcm_valid = 1 for that clk.
  - pcm_valid = 0 otherwise.
  - Output rate = INTERP per frame.
  - Output ramps from the previous frame sum toward the current one; it never reaches the new target within the frame (floor error < 1 LSB × INTERP).
- INTERP = 1: step unused; pcm_out tracks the frame sum with one-frame delay.
- chan_mask is sampled per slot; a change mid-frame affects only later slots.

## Timing
- Registered outputs. pcm_out/pcm_valid update on the clk edge of the qualifying cen.
- Latency: a sum completed at boundary N appears as pcm_out at boundary N+1, i.e. one frame (CH cen) after its last channel slot.
- cen gaps of any length are allowed; state holds when cen = 0.
- Reset:
  - acc, tgt, step, y, pcm_out = 0; pcm_valid = 0.
  - Reset wins over a simultaneous cen.
- Reset mid-frame: the partial sum from the slots after reset becomes the first target; no special handling.
- cur_ch skipping or repeating an index: each accepted slot is added again; no protection.

## Configuration
- JT10_ADPCM_ACCN_SAT_EN:
  - Defined: fmt(y) saturates to W bits. If y > 2^(W−1)−1, output 2^(W−1)−1 (0x7FFF for W=16). If y < −2^(W−1), output −2^(W−1) (0x8000).
  - Undefined: fmt(y) = y[W−1:0] (two's-complement wrap).
  - Internal widths are identical in both builds.

## Test plan
- Defaults, all masks on, every channel 1000 from reset, 2 frames:
  - Frame-1 boundary: pcm_out 0.
  - Boundary 2: pcm_out 0, step 1999.
  - Slots 2/4: pcm_out 1999, 3998.
  - Frame-3 boundary: 6000.
- Same stimulus, chan_mask = 6'b000011:
  - Sum 2000.
  - Step = (2000·21845)>>16 = 666.
  - Outputs 0, 666, 1332, then 2000.
- Negative ramp: steady sum 6000, then all channels −1000:
  - Diff −12000.
  - Step −4000 (floor).
  - Outputs 6000, 2000, −2000, then −6000.
- All channels 0x7FFF for 2 frames:
  - With SAT_EN: pcm_out goes 0 → 0x7FFF and stays.
  - Without: pcm_out = low 16 bits of y (first step 65533 → 0xFFFD).
- pcm_valid count: 10 full frames → exactly 30 pulses. cur_ch = 7 slots injected → no pulse, acc unchanged.
- rst asserted mid-frame together with cen → next clk all outputs 0. Subsequent frames follow scenario 1 values.

Source files
------------

// File: rtl/jt10_adpcm_accn.sv
// ADPCM channel mixer with linear-interpolation upsampler (INTERP outputs per frame).
// Optional saturating output when JT10_ADPCM_ACCN_SAT_EN is defined; otherwise wraps.
module jt10_adpcm_accn #(
  parameter int CH     = 6,
  parameter int W      = 16,
  parameter int INTERP = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic [2:0]          cur_ch,
  input  logic [CH-1:0]       chan_mask,
  input  logic signed [W-1:0] pcm_in,
  output logic signed [W-1:0] pcm_out,
  output logic                pcm_valid
);

  localparam int AW    = W + $clog2(CH);
  localparam int DW    = AW + 1;
  localparam int PW    = DW + 18;
  localparam int RECIP = (65536 + INTERP/2) / INTERP;
  localparam int SLOT  = CH / INTERP;

  logic signed [AW-1:0] acc, tgt, term;
  logic signed [DW-1:0] step, y, y_nxt, diff, step_nxt;
  logic signed [PW-1:0] prod, diff_x, recip_x;
  logic [7:0]           mask8;
  logic                 slot_ok, bound, interp;
  logic [W-1:0]         fmt;

  always_comb begin
    mask8   = 8'(chan_mask);
    slot_ok = {1'b0, cur_ch} < 4'(CH);
    bound   = cen && (cur_ch == 3'd0);
    interp  = 1'b0;
    for (int k = 1; k < INTERP; k++)
      if (cen && ({1'b0, cur_ch} == 4'(k*SLOT))) interp = 1'b1;
    term    = (slot_ok && mask8[cur_ch]) ? {{(AW-W){pcm_in[W-1]}}, pcm_in} : '0;
    // Slope over the frame: (new sum - old target) / INTERP, floored via >>>16
    diff     = {acc[AW-1], acc} - {tgt[AW-1], tgt};
    diff_x   = {{(PW-DW){diff[DW-1]}}, diff};
    recip_x  = PW'(RECIP);
    prod     = diff_x * recip_x;
    step_nxt = DW'(prod >>> 16);
    y_nxt    = bound ? {tgt[AW-1], tgt} : y + step;
  end

`ifdef JT10_ADPCM_ACCN_SAT_EN
  localparam logic signed [DW-1:0] YMAX = {{(DW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [DW-1:0] YMIN = ~YMAX;
  always_comb begin
    if (y_nxt > YMAX)      fmt = {1'b0, {(W-1){1'b1}}};
    else if (y_nxt < YMIN) fmt = {1'b1, {(W-1){1'b0}}};
    else                   fmt = y_nxt[W-1:0];
  end
`else
  always_comb fmt = y_nxt[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      tgt       <= '0;
      step      <= '0;
      y         <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (cen && slot_ok)
        acc <= (cur_ch == 3'd0) ? term : acc + term;
      if (bound) begin
        step <= step_nxt;
        tgt  <= acc;
      end
      if (bound || interp) begin
        y         <= y_nxt;
        pcm_out   <= fmt;
        pcm_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_accn.sv
// Directed bench for jt10_adpcm_accn at default parameters (CH=6, W=16, INTERP=3).
module tb_jt10_adpcm_accn;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cen = 1'b0;
  logic [2:0]         cur_ch = '0;
  logic [5:0]         chan_mask = 6'b111111;
  logic signed [15:0] pcm_in = '0;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;

  int vectors = 0;
  int miscompares = 0;
  logic        obs_valid;
  logic [15:0] obs_out;
  logic [15:0] fo [0:2];
  int          fn;
  int          gap_pulses = 0;

  jt10_adpcm_accn dut (
    .clk(clk), .rst(rst), .cen(cen), .cur_ch(cur_ch), .chan_mask(chan_mask),
    .pcm_in(pcm_in), .pcm_out(pcm_out), .pcm_valid(pcm_valid)
  );

  always #5 clk = ~clk;

  // one slot with cen, followed by one idle cycle (cen gap)
  task automatic do_slot(input logic [2:0] ch, input logic signed [15:0] v);
    cur_ch = ch; pcm_in = v; cen = 1'b1;
    @(posedge clk); #1;
    obs_valid = pcm_valid; obs_out = pcm_out;
    cen = 1'b0;
    @(posedge clk); #1;
    if (pcm_valid) gap_pulses++;
  endtask

  task automatic frame(input logic signed [15:0] v);
    fn = 0;
    for (int c = 0; c < 6; c++) begin
      do_slot(3'(c), v);
      if (obs_valid) begin
        if (fn < 3) fo[fn] = obs_out;
        fn++;
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; cen = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    vectors++;
    if (pcm_out !== 16'd0) begin miscompares++; $display("FAIL reset_out got %h want 0000", pcm_out); end
    vectors++;
    if (pcm_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", pcm_valid); end
  endtask

  task automatic chk3(input string nm, input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] e [0:2];
    e[0] = e0; e[1] = e1; e[2] = e2;
    vectors++;
    if (fn !== 3) begin miscompares++; $display("FAIL %s pulses got %0d want 3", nm, fn); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (fo[i] !== e[i]) begin miscompares++; $display("FAIL %s out[%0d] got %h want %h", nm, i, fo[i], e[i]); end
    end
  endtask

  task automatic test_ramp_up;
    do_reset; chan_mask = 6'b111111;
    frame(16'sd1000); chk3("ramp_f1", 16'd0, 16'd0, 16'd0);
    frame(16'sd1000); chk3("ramp_f2", 16'd0, 16'd1999, 16'd3998);
    frame(16'sd1000); chk3("ramp_f3", 16'd6000, 16'd6000, 16'd6000);
  endtask

  task automatic test_mask;
    do_reset; chan_mask = 6'b000011;
    frame(16'sd1000); chk3("mask_f1", 16'd0, 16'd0, 16'd0);
    frame(16'sd1000); chk3("mask_f2", 16'd0, 16'd666, 16'd1332);
    frame(16'sd1000); chk3("mask_f3", 16'd2000, 16'd2000, 16'd2000);
    chan_mask = 6'b111111;
  endtask

  task automatic test_negative;
    do_reset;
    frame(16'sd1000); frame(16'sd1000); frame(16'sd1000);
    frame(-16'sd1000); chk3("neg_f4", 16'd6000, 16'd6000, 16'd6000);
    frame(-16'sd1000); chk3("neg_f5", 16'd6000, 16'd2000, 16'(-2000));
    frame(-16'sd1000); chk3("neg_f6", 16'(-6000), 16'(-6000), 16'(-6000));
  endtask

  task automatic test_saturate;
    do_reset;
    frame(16'sh7FFF); chk3("sat_f1", 16'd0, 16'd0, 16'd0);
`ifdef JT10_ADPCM_ACCN_SAT_EN
    frame(16'sh7FFF); chk3("sat_f2", 16'd0, 16'h7FFF, 16'h7FFF);
    frame(16'sh7FFF); chk3("sat_f3", 16'h7FFF, 16'h7FFF, 16'h7FFF);
`else
    frame(16'sh7FFF); chk3("wrap_f2", 16'd0, 16'hFFFD, 16'hFFFA);
    frame(16'sh7FFF); chk3("wrap_f3", 16'hFFFA, 16'hFFFA, 16'hFFFA);
`endif
  endtask

  task automatic test_valid_count;
    int pulses;
    do_reset; gap_pulses = 0; pulses = 0;
    for (int f = 0; f < 10; f++) begin
      frame(16'sd1000);
      pulses += fn;
    end
    vectors++;
    if (pulses !== 30) begin miscompares++; $display("FAIL valid_count got %0d want 30", pulses); end
    vectors++;
    if (gap_pulses !== 0) begin miscompares++; $display("FAIL gap_pulses got %0d want 0", gap_pulses); end
    // frame of 500s with out-of-range slots injected mid-frame
    for (int c = 0; c < 6; c++) begin
      do_slot(3'(c), 16'sd500);
      if (c == 2) begin
        do_slot(3'd7, 16'sd5000);
        vectors++;
        if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL inject7_valid got %b want 0", obs_valid); end
        do_slot(3'd6, 16'sd5000);
        vectors++;
        if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL inject6_valid got %b want 0", obs_valid); end
      end
    end
    frame(16'sd500); chk3("inject_f1", 16'd6000, 16'd5000, 16'd4000);
    frame(16'sd500); chk3("inject_f2", 16'd3000, 16'd3000, 16'd3000);
  endtask

  task automatic test_reset_mid;
    do_reset;
    frame(16'sd1000); frame(16'sd1000);
    do_slot(3'd0, 16'sd1000); do_slot(3'd1, 16'sd1000);
    rst = 1'b1; cen = 1'b1; cur_ch = 3'd2; pcm_in = 16'sd1000;
    @(posedge clk); #1;
    vectors++;
    if (pcm_out !== 16'd0) begin miscompares++; $display("FAIL rstmid_out got %h want 0000", pcm_out); end
    vectors++;
    if (pcm_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", pcm_valid); end
    rst = 1'b0; cen = 1'b0;
    @(posedge clk); #1;
    frame(16'sd1000); chk3("rstmid_f1", 16'd0, 16'd0, 16'd0);
    frame(16'sd1000); chk3("rstmid_f2", 16'd0, 16'd1999, 16'd3998);
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_ramp_up;
    test_mask;
    test_negative;
    test_saturate;
    test_valid_count;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
